// File: rtl/fpu_req_arbiter_if.sv
// Request/response bundle between issuing units and the shared bfloat16 fpu arbiter.
// slave = arbiter side, master = requesters plus result consumer.
interface fpu_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [4*NUM_REQ-1:0]  req_op_i;
  logic [16*NUM_REQ-1:0] req_in1_i;
  logic [16*NUM_REQ-1:0] req_in2_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [15:0]           resp_data_o;
  logic                  resp_ovf_o;
  logic [ID_W-1:0]       resp_id_o;

  modport slave (
    input  req_valid_i, req_op_i, req_in1_i, req_in2_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_ovf_o, resp_id_o
  );

  modport master (
    output req_valid_i, req_op_i, req_in1_i, req_in2_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_ovf_o, resp_id_o
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one combinational bfloat16 fpu among NUM_REQ requesters.
// Optional macro FPU_OVF_STICKY_EN adds per-requester sticky overflow flags.
module fpu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fpu_req_arbiter_if.slave bus
`ifdef FPU_OVF_STICKY_EN
  ,
  output logic [NUM_REQ-1:0] ovf_sticky_o,
  input  logic [NUM_REQ-1:0] ovf_clr_i
`endif
);

  typedef logic [ID_W-1:0]    id_t;
  typedef logic [ID_W:0]      wid_t;
  typedef logic [NUM_REQ-1:0] vec_t;

  localparam wid_t NUM_REQ_W = wid_t'(NUM_REQ);
  localparam id_t  LAST_ID   = id_t'(NUM_REQ - 1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Normalise, truncate and saturate; m has the carry at bit 11 and the hidden one at bit 10.
  // Returns {overflow, bf16}; underflow flushes to +0 without a flag.
  function automatic logic [16:0] bf16_pack(input logic s, input logic signed [9:0] e_in,
                                            input logic [11:0] m_in);
    logic signed [9:0] e;
    logic [11:0]       m;
    logic [16:0]       res;
    e   = e_in;
    m   = m_in;
    res = 17'd0;
    if (m != 12'd0) begin
      if (m[11]) begin
        m = m >> 1;
        e = e + 10'sd1;
      end
      for (int i = 0; i < 11; i++) begin
        if (!m[10]) begin
          m = m << 1;
          e = e - 10'sd1;
        end
      end
      if (e >= 10'sd255)    res = {1'b1, s, 8'hFF, 7'h00};
      else if (e > 10'sd0)  res = {1'b0, s, e[7:0], m[9:3]};
    end
    return res;
  endfunction

  function automatic logic [16:0] bf16_addsub(input logic [15:0] a, input logic [15:0] b,
                                              input logic sub);
    logic        sb;
    logic [15:0] big, sml;
    logic        s_big, s_sml;
    logic [11:0] m_big, m_sml, m;
    logic [7:0]  d;
    logic [16:0] res;
    sb = b[15] ^ sub;
    if (b[14:7] == 8'd0) begin
      res = {1'b0, a};
    end else if (a[14:7] == 8'd0) begin
      res = {1'b0, sb, b[14:0]};
    end else begin
      if (a[14:0] >= b[14:0]) begin
        big = a; s_big = a[15]; sml = b; s_sml = sb;
      end else begin
        big = b; s_big = sb;    sml = a; s_sml = a[15];
      end
      d     = big[14:7] - sml[14:7];
      m_big = {2'b01, big[6:0], 3'b000};
      m_sml = {2'b01, sml[6:0], 3'b000} >> d;
      m     = (s_big == s_sml) ? (m_big + m_sml) : (m_big - m_sml);
      res   = bf16_pack(s_big, $signed({2'b00, big[14:7]}), m);
    end
    return res;
  endfunction

  function automatic logic [16:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       prod;
    logic signed [9:0] e;
    logic [16:0]       res;
    res = 17'd0;
    if (a[14:7] != 8'd0 && b[14:7] != 8'd0) begin
      prod = {1'b1, a[6:0]} * {1'b1, b[6:0]};
      e    = $signed({2'b00, a[14:7]}) + $signed({2'b00, b[14:7]}) - 10'sd127;
      res  = bf16_pack(a[15] ^ b[15], e, prod[15:4]);
    end
    return res;
  endfunction

  // Unsupported op codes produce a quiet NaN with no overflow.
  function automatic logic [16:0] fpu_eval(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] res;
    case (op)
      OP_ADD:  res = bf16_addsub(a, b, 1'b0);
      OP_SUB:  res = bf16_addsub(a, b, 1'b1);
      OP_MUL:  res = bf16_mul(a, b);
      default: res = {1'b0, 16'h7FC0};
    endcase
    return res;
  endfunction

  logic [0:0]  state_q;
  id_t         ptr_q;
  logic        vld_p1;
  logic [15:0] data_p1;
  logic        ovf_p1;
  id_t         id_p1;

  logic        slot_free;
  logic        gnt_vld_p0;
  id_t         gnt_id_p0;
  wid_t        cand;
  logic        accept_p0;
  logic [3:0]  op_arr  [NUM_REQ];
  logic [15:0] in1_arr [NUM_REQ];
  logic [15:0] in2_arr [NUM_REQ];
  logic [16:0] fpu_res_p0;

  // ---- stage p0: grant search, operand select, combinational fpu ----
  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_id_p0  = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + wid_t'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!gnt_vld_p0 && bus.req_valid_i[cand[ID_W-1:0]]) begin
        gnt_vld_p0 = 1'b1;
        gnt_id_p0  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      op_arr[k]  = bus.req_op_i[k*4 +: 4];
      in1_arr[k] = bus.req_in1_i[k*16 +: 16];
      in2_arr[k] = bus.req_in2_i[k*16 +: 16];
    end
  end

  assign vld_p1          = (state_q == ST_FULL);
  assign slot_free       = !vld_p1 || bus.resp_ready_i;
  assign accept_p0       = gnt_vld_p0 && slot_free && !rst_i;
  assign bus.req_ready_o = accept_p0 ? (vec_t'(1) << gnt_id_p0) : '0;
  assign fpu_res_p0      = fpu_eval(op_arr[gnt_id_p0], in1_arr[gnt_id_p0], in2_arr[gnt_id_p0]);

  // ---- stage p1: result slot ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else if (accept_p0) begin
      state_q <= ST_FULL;
    end else if (bus.resp_ready_i) begin
      state_q <= ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      data_p1 <= '0;
      ovf_p1  <= 1'b0;
      id_p1   <= '0;
    end else if (accept_p0) begin
      ptr_q   <= (gnt_id_p0 == LAST_ID) ? '0 : gnt_id_p0 + id_t'(1);
      data_p1 <= fpu_res_p0[15:0];
      ovf_p1  <= fpu_res_p0[16];
      id_p1   <= gnt_id_p0;
    end
  end

  assign bus.resp_valid_o = vld_p1;
  assign bus.resp_data_o  = data_p1;
  assign bus.resp_ovf_o   = ovf_p1;
  assign bus.resp_id_o    = id_p1;

`ifdef FPU_OVF_STICKY_EN
  vec_t sticky_q;
  vec_t sticky_set;

  // Set wins over a same-cycle clear so an overflow is never lost.
  assign sticky_set = (vld_p1 && bus.resp_ready_i && ovf_p1) ? (vec_t'(1) << id_p1) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~ovf_clr_i) | sticky_set;
    end
  end

  assign ovf_sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Testbench for fpu_req_arbiter: vector table plus multi-cycle sequences, scoreboarded responses.
// Sticky-flag checks are compiled in when FPU_OVF_STICKY_EN is defined.
module tb_fpu_req_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        o;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
    logic [1:0]  id;
  } sb_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  sb_t  sbq[$];
  logic [15:0] exp_data [4];
  logic        exp_ovf  [4];
  vec_t vecs [10];

  fpu_req_arbiter_if #(.NUM_REQ(4)) bus ();

`ifdef FPU_OVF_STICKY_EN
  logic [3:0] ovf_sticky;
  logic [3:0] ovf_clr;
  fpu_req_arbiter #(.NUM_REQ(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .ovf_sticky_o(ovf_sticky), .ovf_clr_i(ovf_clr)
  );
`else
  fpu_req_arbiter #(.NUM_REQ(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic set_req(input int k, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] d, input logic o);
    bus.req_op_i[k*4 +: 4]    = op;
    bus.req_in1_i[k*16 +: 16] = a;
    bus.req_in2_i[k*16 +: 16] = b;
    exp_data[k]               = d;
    exp_ovf[k]                = o;
    bus.req_valid_i[k]        = 1'b1;
  endtask

  // Pop a completed response before pushing this cycle's accept.
  task automatic sample();
    sb_t e;
    if (!rst) begin
      chk("ready_onehot", 32'($countones(bus.req_ready_o) <= 1), 32'd1);
      if (bus.resp_valid_o && bus.resp_ready_i) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: response data %h id %0d, expected none",
                   bus.resp_data_o, bus.resp_id_o);
        end else begin
          e = sbq.pop_front();
          chk("sb_resp", 32'({bus.resp_data_o, bus.resp_ovf_o, bus.resp_id_o}), 32'(e));
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
          sbq.push_back({exp_data[k], exp_ovf[k], 2'(k)});
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid_i = '0;
    tick();
    rst = 1'b0;
    sbq.delete();
  endtask

  initial begin
    clk   = 1'b0;
    rst   = 1'b1;
    tests = 0;
    fails = 0;
    bus.req_valid_i  = '0;
    bus.req_op_i     = '0;
    bus.req_in1_i    = '0;
    bus.req_in2_i    = '0;
    bus.resp_ready_i = 1'b1;
`ifdef FPU_OVF_STICKY_EN
    ovf_clr = '0;
`endif
    vecs[0] = '{OP_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0};
    vecs[1] = '{OP_MUL, 16'h3F80, 16'h4000, 16'h4000, 1'b0};
    vecs[2] = '{OP_SUB, 16'h4000, 16'h3F80, 16'h3F80, 1'b0};
    vecs[3] = '{OP_ADD, 16'h3F80, 16'hBF80, 16'h0000, 1'b0};
    vecs[4] = '{OP_MUL, 16'h7F00, 16'h7F00, 16'h7F80, 1'b1};
    vecs[5] = '{OP_MUL, 16'hC000, 16'h4040, 16'hC0C0, 1'b0};
    vecs[6] = '{OP_ADD, 16'h0000, 16'h4248, 16'h4248, 1'b0};
    vecs[7] = '{4'hF,   16'h1234, 16'h5678, 16'h7FC0, 1'b0};
    vecs[8] = '{OP_ADD, 16'h7F00, 16'h7F00, 16'h7F80, 1'b1};
    vecs[9] = '{OP_MUL, 16'h0080, 16'h0080, 16'h0000, 1'b0};

    // reset state, with requests pending
    @(negedge clk);
    set_req(0, OP_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    set_req(1, OP_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    #1 chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    tick();
    tick();
    chk("rst_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_data", 32'(bus.resp_data_o), 32'd0);
    chk("rst_ovf", 32'(bus.resp_ovf_o), 32'd0);
    chk("rst_id", 32'(bus.resp_id_o), 32'd0);
    rst = 1'b0;
    bus.req_valid_i = '0;

    // vector table through requester 0, back-to-back
    for (int i = 0; i < 10; i++) begin
      set_req(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].o);
      #1 chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready_o), 32'd1);
      tick();
      bus.req_valid_i = '0;
      chk($sformatf("vec%0d_latency", i), 32'(bus.resp_valid_o), 32'd1);
    end
    tick();

    // round robin, all four requesters valid continuously
    do_reset();
    set_req(0, OP_MUL, 16'h3F80, 16'h4000, 16'h4000, 1'b0);
    set_req(1, OP_MUL, 16'h3F80, 16'h4040, 16'h4040, 1'b0);
    set_req(2, OP_MUL, 16'h3F80, 16'h4080, 16'h4080, 1'b0);
    set_req(3, OP_MUL, 16'h3F80, 16'h40A0, 16'h40A0, 1'b0);
    bus.resp_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("rr_grant%0d", c), 32'(bus.req_ready_o), 32'd1 << (c % 4));
      tick();
    end
    bus.req_valid_i = '0;
    tick();

    // consumer stall with a result held, overflow from requester 2
    do_reset();
    bus.resp_ready_i = 1'b0;
    set_req(2, OP_MUL, 16'h7F00, 16'h7F00, 16'h7F80, 1'b1);
    #1 chk("stall_first_grant", 32'(bus.req_ready_o), 32'b0100);
    tick();
    bus.req_valid_i[2] = 1'b0;
    set_req(0, OP_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_ready", 32'(bus.req_ready_o), 32'd0);
      chk("stall_valid", 32'(bus.resp_valid_o), 32'd1);
      chk("stall_hold", 32'({bus.resp_data_o, bus.resp_ovf_o, bus.resp_id_o}),
          32'({16'h7F80, 1'b1, 2'd2}));
      tick();
    end
    bus.resp_ready_i = 1'b1;
`ifdef FPU_OVF_STICKY_EN
    ovf_clr = 4'b0100;
`endif
    #1 chk("stall_release_grant", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i = '0;
`ifdef FPU_OVF_STICKY_EN
    ovf_clr = '0;
    chk("sticky_set_wins", 32'(ovf_sticky), 32'b0100);
`endif
    tick();
`ifdef FPU_OVF_STICKY_EN
    chk("sticky_hold", 32'(ovf_sticky), 32'b0100);
    ovf_clr = 4'b0100;
    tick();
    ovf_clr = '0;
    chk("sticky_clear", 32'(ovf_sticky), 32'd0);
`endif

    // reset while a result is pending and requests are valid
    bus.resp_ready_i = 1'b0;
    set_req(1, OP_MUL, 16'h3F80, 16'h4040, 16'h4040, 1'b0);
    #1 chk("mid_grant", 32'(bus.req_ready_o), 32'b0010);
    tick();
    chk("mid_valid", 32'(bus.resp_valid_o), 32'd1);
    rst = 1'b1;
    set_req(0, OP_ADD, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    #1 chk("mid_rst_ready", 32'(bus.req_ready_o), 32'd0);
    tick();
    rst = 1'b0;
    sbq.delete();
    chk("mid_rst_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("mid_rst_data", 32'(bus.resp_data_o), 32'd0);
    set_req(2, OP_SUB, 16'h4040, 16'h3F80, 16'h4000, 1'b0);
    bus.req_valid_i  = 4'b0101;
    bus.resp_ready_i = 1'b1;
    #1 chk("mid_rst_next_grant", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i = '0;
    tick();

    // pointer is 1: lone requester 3 wins, then pointer wraps to 0
    set_req(3, OP_SUB, 16'h4000, 16'h3F80, 16'h3F80, 1'b0);
    #1 chk("wrap_grant3", 32'(bus.req_ready_o), 32'b1000);
    tick();
    bus.req_valid_i = 4'b1001;
    #1 chk("wrap_grant0", 32'(bus.req_ready_o), 32'b0001);
    tick();
    bus.req_valid_i = '0;
    tick();

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
